// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
//
// Resolves one RV32I conditional branch at a time. A request is accepted
// in IDLE, evaluated for one cycle against the external comparator's
// results, and compared with the prediction that was made when the request
// was presented. A correct prediction returns straight to IDLE. A wrong
// prediction issues a one-cycle redirect to the corrected fetch address.
// Flush is then held for FLUSH_CYCLES more cycles.
//
// Optional feature macro: BRANCH_PRED_EN
//   defined   -> 16-entry table of 2-bit saturating counters, indexed by
//                req_pc[5:2], supplies pred_taken
//   undefined -> pred_taken is tied to 0 (static not-taken)
//
// Ports
//   clk            in   1   single clock, rising edge
//   rst            in   1   asynchronous active-high reset
//   req_valid      in   1   branch instruction presented
//   req_ready      out  1   controller can accept a request (IDLE only)
//   req_funct3     in   3   RV32I branch funct3
//   req_pc         in   32  PC of the branch
//   req_imm        in   32  sign-extended B-immediate
//   cmp_brun       out  1   comparator select: 1 unsigned, 0 signed
//   cmp_breq       in   1   comparator equal result
//   cmp_brlt       in   1   comparator less-than result
//   pred_taken     out  1   prediction for the request currently presented
//   redirect_valid out  1   single-cycle PC redirect strobe
//   redirect_pc    out  32  corrected fetch address
//   flush          out  1   kill younger instructions
//   resolved       out  1   single-cycle strobe when a branch completes
// ---------------------------------------------------------------------------
module branch_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_imm,
  output logic        cmp_brun,
  input  logic        cmp_breq,
  input  logic        cmp_brlt,
  output logic        pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        resolved
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    REDIRECT,
    FLUSH
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_funct3;
  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic        r_pred;
  logic [31:0] r_redirectPc;
  logic [2:0]  r_flushCnt;

  logic        w_handshake;
  logic        w_taken;
  logic        w_mispredict;
  logic [31:0] w_target;

  assign w_handshake = req_valid && (r_state == IDLE);

  // Branch condition from the latched funct3. Encodings 010/011 are not
  // branches and resolve as not taken.
  always_comb begin
    w_taken = 1'b0;
    case (r_funct3)
      3'b000:         w_taken = cmp_breq;
      3'b001:         w_taken = !cmp_breq;
      3'b100, 3'b110: w_taken = cmp_brlt;
      3'b101, 3'b111: w_taken = !cmp_brlt;
      default:        w_taken = 1'b0;
    endcase
  end

  // Both target additions wrap modulo 2^32 by truncation.
  assign w_target     = w_taken ? (r_pc + r_imm) : (r_pc + 32'd4);
  assign w_mispredict = (w_taken != r_pred);

  // Next-state logic and the state-decoded strobes.
  always_comb begin
    w_nextState    = r_state;
    req_ready      = 1'b0;
    cmp_brun       = 1'b0;
    resolved       = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_handshake) w_nextState = EVAL;
      end
      EVAL: begin
        cmp_brun    = (r_funct3[2:1] == 2'b11);
        resolved    = 1'b1;
        w_nextState = w_mispredict ? REDIRECT : IDLE;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        w_nextState    = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if (r_flushCnt <= 3'd1) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign redirect_pc = r_redirectPc;

  // State register, request capture, redirect target and flush counter.
  // The redirect target is written only on a mispredict so it stays
  // stable through FLUSH and IDLE until another redirect replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_funct3     <= 3'd0;
      r_pc         <= 32'd0;
      r_imm        <= 32'd0;
      r_pred       <= 1'b0;
      r_redirectPc <= 32'd0;
      r_flushCnt   <= 3'd0;
    end else begin
      r_state <= w_nextState;
      if (w_handshake) begin
        r_funct3 <= req_funct3;
        r_pc     <= req_pc;
        r_imm    <= req_imm;
        r_pred   <= pred_taken;
      end
      if ((r_state == EVAL) && w_mispredict) r_redirectPc <= w_target;
      if (r_state == REDIRECT) r_flushCnt <= 3'(FLUSH_CYCLES);
      else if ((r_state == FLUSH) && (r_flushCnt != 3'd0)) r_flushCnt <= r_flushCnt - 3'd1;
    end
  end

`ifdef BRANCH_PRED_EN
  logic [1:0] r_table [16];

  assign pred_taken = r_table[req_pc[5:2]][1];

  // Counter of the branch being evaluated moves toward its outcome and
  // saturates at 11 / 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_table[i] <= 2'b01;
    end else if (r_state == EVAL) begin
      if (w_taken && (r_table[r_pc[5:2]] != 2'b11))
        r_table[r_pc[5:2]] <= r_table[r_pc[5:2]] + 2'b01;
      else if (!w_taken && (r_table[r_pc[5:2]] != 2'b00))
        r_table[r_pc[5:2]] <= r_table[r_pc[5:2]] - 2'b01;
    end
  end
`else
  assign pred_taken = 1'b0;
`endif

endmodule
